// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Groups the signals around the shared memory port arbiter:
//   - fetch side  : inst_req/inst_addr in, inst_rdata/inst_data_ok out
//   - data side   : data_req/wr/size/addr/wdata in, data_rdata/data_data_ok out
//   - memory port : bus_req/wr/size/addr/wdata out, bus_addr_ok/data_ok/rdata in
//   - status      : busy (arbiter has a transaction in flight)
// Modports:
//   slave  - the arbiter itself (receives requests, drives the memory port)
//   master - the environment (pipeline requesters and the memory slave)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;
    // Fetch requester
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;
    // Data requester
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_data_ok;
    // Shared memory port
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    // Status
    logic        busy;

    modport slave (
        input  inst_req, inst_addr,
        output inst_rdata, inst_data_ok,
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_rdata, data_data_ok,
        output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata,
        output busy
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_rdata, inst_data_ok,
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_rdata, data_data_ok,
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one sram-like memory port between instruction fetch and data access.
// Data requests win by default; a run counter of consecutive data grants
// (taken while fetch is waiting) forces a fetch grant once it reaches
// MAX_DATA_RUN so fetch cannot starve. Exactly one transaction is in flight,
// sequenced IDLE -> ADDR (address phase) -> [WAIT (data phase)] -> IDLE.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   port - mem_port_arbiter_if.slave (requesters, memory port, busy)
// Parameters:
//   MAX_DATA_RUN - consecutive data grants allowed while fetch waits (>= 1)
//   CNT_W        - run counter width, 2**CNT_W > MAX_DATA_RUN
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int MAX_DATA_RUN = 4,
    parameter int CNT_W        = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_arbiter_if.slave     port
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_DATA_RUN);

    // Owner encoding
    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    logic [1:0]       r_state;
    logic             r_owner;
    logic             r_wr;
    logic [1:0]       r_size;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [CNT_W-1:0] r_run;

    logic [1:0]       w_state_nxt;
    logic             w_grant;
    logic             w_grant_owner;
    logic             w_complete;

    // Arbitration and next-state selection
    always_comb begin
        w_state_nxt   = r_state;
        w_grant       = 1'b0;
        w_grant_owner = OWN_INST;
        case (r_state)
            ST_IDLE: begin
                if (port.data_req && port.inst_req) begin
                    w_grant       = 1'b1;
                    // Fetch is forced only once the data run has saturated
                    w_grant_owner = (r_run == RUN_MAX) ? OWN_INST : OWN_DATA;
                end else if (port.data_req) begin
                    w_grant       = 1'b1;
                    w_grant_owner = OWN_DATA;
                end else if (port.inst_req) begin
                    w_grant       = 1'b1;
                    w_grant_owner = OWN_INST;
                end else begin
                    w_grant       = 1'b0;
                end
                if (w_grant) begin
                    w_state_nxt = ST_ADDR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ADDR: begin
                // data_ok without addr_ok is not a valid completion here
                if (port.bus_addr_ok) begin
                    w_state_nxt = port.bus_data_ok ? ST_IDLE : ST_WAIT;
                end else begin
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_WAIT: begin
                if (port.bus_data_ok) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Completion is the same cycle the slave signals data_ok in a live phase
    always_comb begin
        w_complete = 1'b0;
        case (r_state)
            ST_ADDR: w_complete = port.bus_addr_ok & port.bus_data_ok;
            ST_WAIT: w_complete = port.bus_data_ok;
            default: w_complete = 1'b0;
        endcase
    end

    // State, owner, transaction latches and starvation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_INST;
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_run   <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_owner <= w_grant_owner;
                if (w_grant_owner == OWN_DATA) begin
                    r_wr    <= port.data_wr;
                    r_size  <= port.data_size;
                    r_addr  <= port.data_addr;
                    r_wdata <= port.data_wdata;
                    // Count only runs that actually keep fetch waiting
                    if (port.inst_req) begin
                        r_run <= (r_run == RUN_MAX) ? r_run : (r_run + {{(CNT_W-1){1'b0}}, 1'b1});
                    end else begin
                        r_run <= {CNT_W{1'b0}};
                    end
                end else begin
                    r_wr    <= 1'b0;
                    r_size  <= 2'd2;
                    r_addr  <= port.inst_addr;
                    r_wdata <= 32'd0;
                    r_run   <= {CNT_W{1'b0}};
                end
            end else begin
                r_owner <= r_owner;
                r_wr    <= r_wr;
                r_size  <= r_size;
                r_addr  <= r_addr;
                r_wdata <= r_wdata;
                r_run   <= r_run;
            end
        end
    end

    // Memory port is driven only from latched values, never live inputs
    assign port.bus_req   = (r_state == ST_ADDR);
    assign port.bus_wr    = r_wr;
    assign port.bus_size  = r_size;
    assign port.bus_addr  = r_addr;
    assign port.bus_wdata = r_wdata;
    assign port.busy      = (r_state != ST_IDLE);

    // Completion pulses and read data routed to the owner only
    assign port.inst_data_ok = w_complete & (r_owner == OWN_INST);
    assign port.data_data_ok = w_complete & (r_owner == OWN_DATA);
    assign port.inst_rdata   = port.inst_data_ok ? port.bus_rdata : 32'd0;
    assign port.data_rdata   = port.data_data_ok ? port.bus_rdata : 32'd0;

endmodule
